// File: rtl/rmii_recv_byte.sv
// RMII receive path: finds preamble and SFD, then assembles LSB-first dibits into bytes.
// Supports 100 Mbit/s (sample every rmii_clk) and 10 Mbit/s (sample every 10th rmii_clk).
module rmii_recv_byte #(
  parameter int unsigned Npre = 4,
  parameter int unsigned Nlen = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rmii_clk,
  input  logic            fast_eth,
  input  logic [1:0]      rm_rx,
  input  logic            rm_crs_dv,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            rx_sof,
  output logic            rx_eof,
  output logic            rx_err,
  output logic [Nlen-1:0] rx_len,
  output logic            busy
);

  localparam int unsigned PW = $clog2(Npre + 2);
  localparam logic [PW-1:0]   PRE_MAX = PW'(Npre);
  localparam logic [Nlen-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t        state;
  logic [3:0]    div;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    dcnt;
  logic [5:0]    shreg;
  logic          sof_pend;
  logic          sample_en;

  // 10 Mbit/s dibits last ten rmii_clk periods; sample on the last one.
  assign sample_en = rmii_clk & (fast_eth | (div == 4'd9));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      pre_cnt  <= '0;
      dcnt     <= '0;
      shreg    <= '0;
      sof_pend <= 1'b0;
      rx_data  <= '0;
      rx_len   <= '0;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;

      // Divider is parked at 0 while the line is quiet so the first dibit aligns.
      if (state == IDLE && !rm_crs_dv) begin
        div <= '0;
      end else if (rmii_clk) begin
        div <= (div == 4'd9) ? 4'd0 : div + 4'd1;
      end

      if (sample_en) begin
        case (state)
          IDLE: begin
            if (rm_crs_dv) begin
              if (rm_rx == 2'b01) begin
                state   <= PRE;
                pre_cnt <= PW'(1);
                busy    <= 1'b1;
              end else if (rm_rx != 2'b00) begin
                state <= DROP;
                busy  <= 1'b1;
              end
            end
          end

          PRE: begin
            if (!rm_crs_dv) begin
              state <= DROP;
            end else begin
              case (rm_rx)
                2'b01: begin
                  if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + PW'(1);
                end
                2'b11: begin
                  if (pre_cnt >= PRE_MAX) begin
                    state    <= DATA;
                    rx_len   <= '0;
                    dcnt     <= '0;
                    sof_pend <= 1'b1;
                  end else begin
                    state <= DROP;
                  end
                end
                default: state <= DROP;
              endcase
            end
          end

          DATA: begin
            if (rm_crs_dv) begin
              dcnt  <= dcnt + 2'd1;
              shreg <= {rm_rx, shreg[5:2]};
              if (dcnt == 2'd3) begin
                rx_data  <= {rm_rx, shreg};
                rx_valid <= 1'b1;
                rx_sof   <= sof_pend;
                sof_pend <= 1'b0;
                if (rx_len != LEN_MAX) rx_len <= rx_len + Nlen'(1);
              end
            end else begin
              // Carrier drop mid-byte is an alignment error; partial byte is discarded.
              rx_eof   <= 1'b1;
              rx_err   <= (dcnt != 2'd0);
              dcnt     <= '0;
              sof_pend <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end

          DROP: begin
            if (!rm_crs_dv) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rmii_recv_byte.sv
// Directed bench for rmii_recv_byte: scoreboard of expected output events, checked at negedge.
module tb_rmii_recv_byte;

  logic       clk = 1'b0;
  logic       rst, rmii_clk, fast_eth, rm_crs_dv;
  logic [1:0] rm_rx;

  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_err, busy;
  logic [10:0] rx_len;

  logic [7:0] u6_data;
  logic       u6_valid, u6_sof, u6_eof, u6_err, u6_busy;
  logic [2:0] u6_len;

  rmii_recv_byte dut (
    .clk(clk), .rst(rst), .rmii_clk(rmii_clk), .fast_eth(fast_eth),
    .rm_rx(rm_rx), .rm_crs_dv(rm_crs_dv),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_err(rx_err), .rx_len(rx_len), .busy(busy)
  );

  rmii_recv_byte #(.Npre(4), .Nlen(3)) u6 (
    .clk(clk), .rst(rst), .rmii_clk(rmii_clk), .fast_eth(fast_eth),
    .rm_rx(rm_rx), .rm_crs_dv(rm_crs_dv),
    .rx_data(u6_data), .rx_valid(u6_valid), .rx_sof(u6_sof), .rx_eof(u6_eof),
    .rx_err(u6_err), .rx_len(u6_len), .busy(u6_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] data;
  } ev_t;

  ev_t        sb[$];
  ev_t        e;
  logic [7:0] pay [16];
  int         npay;
  int         nvec = 0;
  int         nfail = 0;
  int         hold = 1;
  int         cyc = 0;
  int         last_cyc = 0;
  int         cnt6 = 0;
  logic       spacing = 1'b0;
  logic       first_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clk and compare any output pulse against the scoreboard.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (u6_valid) cnt6++;
    if (rx_valid | rx_eof | rx_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, rx_valid, rx_eof, rx_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("flags", {28'd0, rx_valid, rx_sof, rx_eof, rx_err},
            {28'd0, e.valid, e.sof, e.eof, e.err});
        if (e.valid) begin
          chk("data", {24'd0, rx_data}, {24'd0, e.data});
          if (spacing && !e.sof) chk("valid_spacing", cyc - last_cyc, 32'd80);
          last_cyc = cyc;
        end
      end
    end
  endtask

  task automatic send_dibit(input logic [1:0] d, input logic dv);
    for (int i = 0; i < hold; i++) begin
      rm_rx = d; rm_crs_dv = dv; rmii_clk = 1'b0;
      tick();
      rmii_clk = 1'b1;
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 4; i++) send_dibit(v[2*i +: 2], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_dibit(2'b00, 1'b0);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    first_pending = 1'b1;
  endtask

  task automatic payload();
    for (int i = 0; i < npay; i++) begin
      sb.push_back('{valid: 1'b1, sof: first_pending, eof: 1'b0, err: 1'b0, data: pay[i]});
      first_pending = 1'b0;
      send_byte(pay[i]);
    end
  endtask

  task automatic end_frame(input logic err);
    sb.push_back('{valid: 1'b0, sof: 1'b0, eof: 1'b1, err: err, data: 8'h00});
    send_dibit(2'b00, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; rmii_clk = 1'b0; rm_crs_dv = 1'b0; rm_rx = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rmii_clk = 1'b0; fast_eth = 1'b1; rm_rx = 2'b00; rm_crs_dv = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset_flags", {27'd0, rx_valid, rx_sof, rx_eof, rx_err, busy}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_len", {21'd0, rx_len}, 32'd0);

    // Test 1: 100 Mbit/s clean frame
    idle(4);
    npay = 3; pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'hAB;
    preamble();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    payload();
    end_frame(1'b0);
    idle(3);
    chk("t1_len", {21'd0, rx_len}, 32'd3);
    chk("t1_leftover", sb.size(), 32'd0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);

    // Test 2: 10 Mbit/s, same frame
    fast_eth = 1'b0; hold = 10; spacing = 1'b1;
    idle(2);
    preamble();
    payload();
    end_frame(1'b0);
    idle(2);
    chk("t2_len", {21'd0, rx_len}, 32'd3);
    chk("t2_leftover", sb.size(), 32'd0);
    fast_eth = 1'b1; hold = 1; spacing = 1'b0;
    idle(2);

    // Test 3: short preamble, frame dropped
    for (int i = 0; i < 3; i++) send_dibit(2'b01, 1'b1);
    send_dibit(2'b11, 1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    send_dibit(2'b00, 1'b0);
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    chk("t3_len_held", {21'd0, rx_len}, 32'd3);
    idle(2);

    // Test 4: trailing partial byte
    npay = 1; pay[0] = 8'h5A;
    preamble();
    payload();
    send_dibit(2'b01, 1'b1);
    send_dibit(2'b10, 1'b1);
    end_frame(1'b1);
    idle(2);
    chk("t4_len", {21'd0, rx_len}, 32'd1);
    chk("t4_leftover", sb.size(), 32'd0);

    // Test 5: reset mid-frame, then clean frame
    npay = 2; pay[0] = 8'h12; pay[1] = 8'h34;
    preamble();
    payload();
    reset_pulse();
    chk("t5_rst_flags", {27'd0, rx_valid, rx_sof, rx_eof, rx_err, busy}, 32'd0);
    chk("t5_rst_data", {24'd0, rx_data}, 32'd0);
    chk("t5_rst_len", {21'd0, rx_len}, 32'd0);
    send_byte(8'hAB);
    chk("t5_drop_busy", {31'd0, busy}, 32'd1);
    send_dibit(2'b00, 1'b0);
    idle(2);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    npay = 1; pay[0] = 8'hFF;
    preamble();
    payload();
    end_frame(1'b0);
    idle(2);
    chk("t5_len", {21'd0, rx_len}, 32'd1);
    chk("t5_leftover", sb.size(), 32'd0);

    // Test 6: 9-byte frame, rx_len saturation on the Nlen=3 instance
    reset_pulse();
    chk("t6_u6_rst", {26'd0, u6_valid, u6_sof, u6_eof, u6_err, u6_busy, 1'b0}, 32'd0);
    cnt6 = 0;
    idle(2);
    npay = 9;
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h21 + 8'(i * 17));
    preamble();
    payload();
    end_frame(1'b0);
    idle(2);
    chk("t6_u6_valids", cnt6, 32'd9);
    chk("t6_u6_len", {29'd0, u6_len}, 32'd7);
    chk("t6_u6_data", {24'd0, u6_data}, {24'd0, pay[8]});
    chk("t6_len", {21'd0, rx_len}, 32'd9);
    chk("t6_leftover", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/rmii_recv_byte.md
RMII_RECV_BYTE -- requirements
Module: rmii_recv_byte

Interface
REQ-001 SHALL have parameter Npre, default 4: minimum count of 01 preamble dibits required before the SFD dibit.
REQ-002 SHALL have parameter Nlen, default 11: width of the received-byte counter.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; all logic runs on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port rmii_clk  input  1  RMII clock level (clk/2 toggle); a clk cycle with rmii_clk=1 is an enable cycle.
REQ-006 SHALL have port fast_eth  input  1  1 = 100 Mbit/s, 0 = 10 Mbit/s.
REQ-007 SHALL have port rm_rx  input  2  RMII receive dibit.
REQ-008 SHALL have port rm_crs_dv  input  1  RMII carrier sense / data valid.
REQ-009 SHALL have port rx_data  output  8  last assembled byte.
REQ-010 SHALL have port rx_valid  output  1  one-clk pulse: rx_data holds a new byte.
REQ-011 SHALL have port rx_sof  output  1  high together with rx_valid for the first byte after the SFD.
REQ-012 SHALL have port rx_eof  output  1  one-clk pulse at frame end.
REQ-013 SHALL have port rx_err  output  1  one-clk pulse: frame aborted or misaligned.
REQ-014 SHALL have port rx_len  output  Nlen  bytes received in the current or last frame.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL take a sample on a clk edge where sample_en=1; fast_eth=1: sample_en = rmii_clk; fast_eth=0: sample_en = rmii_clk AND div==9.
REQ-017 SHALL keep div as a 4-bit counter, +1 per enable cycle, wrap 9->0, held at 0 in IDLE while rm_crs_dv=0.
REQ-018 SHALL implement states IDLE, PRE, DATA and DROP; non-sample cycles never change state.
REQ-019 IDLE: crs_dv=1 & dibit 01 -> PRE with pre_cnt=1; crs_dv=1 & dibit 00 -> stay; any other dibit -> DROP.
REQ-020 PRE: dibit 01 -> pre_cnt+1, saturating at Npre; dibit 11 with pre_cnt>=Npre -> DATA with rx_len=0 and dibit count=0.
REQ-021 PRE: dibit 11 with pre_cnt<Npre, dibit 00 or 10, or crs_dv=0 -> DROP; none of these pulse any output.
REQ-022 DATA: each sample with crs_dv=1 shifts the dibit in LSB-first, giving byte = {d3,d2,d1,d0}, first-received dibit in bits [1:0].
REQ-023 On the 4th dibit, the SHALL set rx_data and pulse rx_valid on the clk edge after that sample; latency is 1 clk.
REQ-024 On the same edge, the block SHALL increment rx_len, saturating at 2^Nlen-1.
REQ-025 A sample with crs_dv=0 in DATA SHALL pulse rx_eof on the next edge and go to IDLE; rx_len holds its final count until the next SFD.
REQ-026 If that crs_dv=0 sample arrives with dibit count != 0, the block SHALL pulse rx_err on the same edge as rx_eof and discard the partial byte.
REQ-027 If crs_dv=0 arrives in DATA with rx_len=0, the block SHALL pulse rx_eof only.
REQ-028 DROP SHALL ignore dibits and return to IDLE on the first sample with crs_dv=0; no outputs pulse.
REQ-029 rx_sof SHALL be 1 only with the first rx_valid of each frame.
REQ-030 rx_valid, rx_eof and rx_err SHALL never be high for two consecutive clk cycles.

Reset
REQ-031 With rst=1 at a clk edge, the block SHALL set state=IDLE, div=0, pre_cnt=0 and dibit count=0.
REQ-032 With rst=1 at a clk edge, the block SHALL set rx_data=0, rx_len=0, and rx_valid, rx_sof, rx_eof, rx_err and busy to 0.
REQ-033 If rst rises mid-frame, the block SHALL emit no rx_eof or rx_err for that frame.
REQ-034 After reset, a frame already in progress SHALL be re-synchronised only through IDLE; the block returns to IDLE via DROP on its next crs_dv=0 sample.

Verification
REQ-035 Test 1, fast_eth=1: 7x55 preamble, D5, then bytes 0x12 0x34 0xAB, then crs_dv=0. Expected: three rx_valid with data 12, 34, AB; rx_sof on the first only; one rx_eof; rx_len=3; rx_err never pulses.
REQ-036 Test 2, fast_eth=0, same frame with each dibit held 10 rmii_clk periods. Expected: identical output sequence; rx_valid pulses spaced 40 rmii_clk periods apart.
REQ-037 Test 3: preamble of only 3 dibits of 01, then 11, then data. Expected: no rx_valid or rx_eof; busy stays high until crs_dv=0.
REQ-038 Test 4: byte 0x5A followed by 2 extra dibits, then crs_dv=0. Expected: one rx_valid with data 5A; rx_eof and rx_err on the same clk edge; rx_len=1.
REQ-039 Test 5: rst=1 for one clk after the 2nd data byte. Expected: all outputs 0 on the next edge; no rx_eof; the following clean frame 0xFF is received with rx_len=1.
REQ-040 Test 6: Nlen=3, frame of 9 bytes. Expected: rx_len saturates at 7; all 9 rx_valid pulses occur.
